// File: rtl/sprite_arb_pkg.sv
// Shared types and constants for the sprite ROM arbiter.
// Optional build macro used by the arbiter: SPRITE_ARB_FIXED_PRIO_EN.
package sprite_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Index width covers the largest supported renderer count (8).
  localparam int NUM_REQ_MAX = 8;
  localparam int IDX_W       = $clog2(NUM_REQ_MAX);
  localparam int MAX_ROM_LAT = 3;
  localparam int CNT_W       = $clog2(MAX_ROM_LAT + 1);

endpackage

// File: rtl/sprite_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// otherwise the lowest set request (wrap-around).
module sprite_arb_rr_pick
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               found
);

  logic             hi_found;
  logic [IDX_W-1:0] hi_idx;
  logic             lo_found;
  logic [IDX_W-1:0] lo_idx;

  // Descending scan so the last hit is the lowest index in each range.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (IDX_W'(i) >= rr_ptr)) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(i);
      end
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
      end
    end
    found  = lo_found;
    winner = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite bitmap ROM among NUM_REQ renderers, round-robin by default.
// Define SPRITE_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      line_start,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         rom_addr,
  output logic                      rom_en,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      busy,
  output state_t                    fsm_state
);

  // Handshake: a requester holds req/req_addr until its one-cycle rsp_valid;
  // the arbiter samples them only in IDLE and always completes a granted fetch.

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((ROM_LAT > 0) ? (ROM_LAT - 1) : 0);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    w_q, w_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_d, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_d;
  logic [ADDR_W-1:0]   rom_addr_d;
  logic                rom_en_d;
  logic [IDX_W-1:0]    pick_base;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_found;
  logic [ADDR_W-1:0]   pick_addr;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
  assign pick_base = '0;
`else
  logic [IDX_W-1:0] rr_q, rr_d;
  assign pick_base = rr_q;
`endif

  assign fsm_state = state_q;

  sprite_arb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req),
    .rr_ptr (pick_base),
    .winner (pick_idx),
    .found  (pick_found)
  );

  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REQ; i++) oh[i] = (idx == IDX_W'(i));
    return oh;
  endfunction

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data;
    rom_addr_d  = rom_addr;
    rom_en_d    = 1'b0;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
    rr_d        = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          w_d        = pick_idx;
          addr_d     = pick_addr;
          gnt_d      = to_onehot(pick_idx);
          rom_en_d   = 1'b1;
          rom_addr_d = pick_addr;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (ROM_LAT == 0) begin
          rsp_data_d  = rom_data;
          rsp_valid_d = to_onehot(w_q);
          state_d     = RESP;
        end else begin
          cnt_d    = '0;
          rom_en_d = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAST_CNT) begin
          rsp_data_d  = rom_data;
          rsp_valid_d = to_onehot(w_q);
          state_d     = RESP;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          rom_en_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
        rr_d = (w_q == IDX_W'(NUM_REQ - 1)) ? '0 : (w_q + IDX_W'(1));
`endif
      end
      default: state_d = IDLE;
    endcase
`ifndef SPRITE_ARB_FIXED_PRIO_EN
    // A scanline start overrides the post-response pointer advance.
    if (line_start) rr_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      w_q       <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rom_addr  <= '0;
      rom_en    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      gnt       <= gnt_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rom_addr  <= rom_addr_d;
      rom_en    <= rom_en_d;
      busy      <= (state_d != IDLE);
    end
  end

`ifndef SPRITE_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: two instances (ROM_LAT 0 and 2) driven by
// protocol-following requesters, checked against a transaction-level model.
module tb_sprite_rom_arbiter;
  import sprite_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int L  = 2;

  logic               clk;
  logic               reset;
  logic               line_start;
  logic [N-1:0]       req       [L];
  logic [N*AW-1:0]    req_addr  [L];
  logic [N-1:0]       gnt       [L];
  logic [N-1:0]       rsp_valid [L];
  logic [DW-1:0]      rsp_data  [L];
  logic [AW-1:0]      rom_addr  [L];
  logic               rom_en    [L];
  logic [DW-1:0]      rom_data  [L];
  logic               busy      [L];
  state_t             fsm_state [L];

  logic [DW-1:0]      rom_mem [16];
  logic [DW-1:0]      junk;
  logic [AW-1:0]      a1_p1, a1_p2;
  logic               e1_p1, e1_p2;
  logic [N-1:0]       wait_rsp [L];
  int                 cyc = 0;
  int                 checks = 0;
  int                 errors = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs and ROM models ----------------
  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(0)) dut0 (
    .clk(clk), .reset(reset), .line_start(line_start),
    .req(req[0]), .req_addr(req_addr[0]), .gnt(gnt[0]), .rsp_valid(rsp_valid[0]),
    .rsp_data(rsp_data[0]), .rom_addr(rom_addr[0]), .rom_en(rom_en[0]),
    .rom_data(rom_data[0]), .busy(busy[0]), .fsm_state(fsm_state[0])
  );

  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(2)) dut1 (
    .clk(clk), .reset(reset), .line_start(line_start),
    .req(req[1]), .req_addr(req_addr[1]), .gnt(gnt[1]), .rsp_valid(rsp_valid[1]),
    .rsp_data(rsp_data[1]), .rom_addr(rom_addr[1]), .rom_en(rom_en[1]),
    .rom_data(rom_data[1]), .busy(busy[1]), .fsm_state(fsm_state[1])
  );

  // Latency-2 ROM shows garbage until two cycles after an enabled address.
  always @(posedge clk) begin
    junk  <= DW'($urandom);
    a1_p1 <= rom_addr[1];
    a1_p2 <= a1_p1;
    e1_p1 <= rom_en[1];
    e1_p2 <= e1_p1;
  end
  assign rom_data[0] = rom_en[0] ? rom_mem[rom_addr[0]] : junk;
  assign rom_data[1] = e1_p2 ? rom_mem[a1_p2] : junk;

  function automatic int ref_pick(input logic [N-1:0] r, input int p);
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (r[k]) return k;
`else
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
`endif
    return -1;
  endfunction

  // ---------------- reference model + scoreboard per instance ----------------
  for (genvar l = 0; l < L; l++) begin : lane_g
    localparam int LAT = (l == 0) ? 0 : 2;
    logic [47:0]   exp_gnt_q[$];
    logic [47:0]   exp_rsp_q[$];
    int            free_at, resp_at, ptr, last_w, en_from, en_to, w;
    logic [AW-1:0] en_addr, a;
    logic          m_en, m_busy;
    logic [47:0]   e;

    initial begin
      free_at = 0; resp_at = -1; ptr = 0; last_w = 0; en_from = -1; en_to = -2;
      en_addr = '0;
      forever begin
        @(posedge clk);
        if (reset) begin
          exp_gnt_q.delete();
          exp_rsp_q.delete();
          free_at = 0; resp_at = -1; ptr = 0; en_from = -1; en_to = -2;
        end else begin
          if (cyc >= free_at && req[l] != '0) begin
            w = ref_pick(req[l], ptr);
            a = req_addr[l][w*AW +: AW];
            exp_gnt_q.push_back({32'(cyc + 1), 8'(1 << w), 8'(a)});
            exp_rsp_q.push_back({32'(cyc + 2 + LAT), 8'(1 << w), rom_mem[a]});
            free_at = cyc + 3 + LAT;
            resp_at = cyc + 2 + LAT;
            last_w  = w;
            en_from = cyc + 1;
            en_to   = cyc + 1 + LAT;
            en_addr = a;
          end
          if (cyc == resp_at) ptr = (last_w + 1) % N;
          if (line_start) ptr = 0;
        end
      end
    end

    initial forever begin
      @(negedge clk);
      if (!reset) begin
        m_en   = (cyc >= en_from) && (cyc <= en_to);
        m_busy = (cyc >= en_from) && (cyc <= en_to + 1);
        checks++;
        if (rom_en[l] !== m_en || busy[l] !== m_busy || (m_en && rom_addr[l] !== en_addr)) begin
          errors++;
          $display("FAIL rom_busy lane%0d cyc%0d got en=%b busy=%b addr=%h want en=%b busy=%b addr=%h",
                   l, cyc, rom_en[l], busy[l], rom_addr[l], m_en, m_busy, en_addr);
        end
        if (gnt[l] != '0 || (exp_gnt_q.size() > 0 && int'(exp_gnt_q[0][47:16]) == cyc)) begin
          checks++;
          if (exp_gnt_q.size() == 0) begin
            errors++;
            $display("FAIL gnt_unexpected lane%0d cyc%0d got gnt=%b want none", l, cyc, gnt[l]);
          end else begin
            e = exp_gnt_q.pop_front();
            if (int'(e[47:16]) != cyc || {4'b0, gnt[l]} !== e[15:8] || {4'b0, rom_addr[l]} !== e[7:0]) begin
              errors++;
              $display("FAIL gnt lane%0d cyc%0d got gnt=%b addr=%h want cyc%0d gnt=%b addr=%h",
                       l, cyc, gnt[l], rom_addr[l], e[47:16], e[11:8], e[3:0]);
            end
          end
        end
        if (rsp_valid[l] != '0 || (exp_rsp_q.size() > 0 && int'(exp_rsp_q[0][47:16]) == cyc)) begin
          checks++;
          if (exp_rsp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected lane%0d cyc%0d got rsp_valid=%b want none", l, cyc, rsp_valid[l]);
          end else begin
            e = exp_rsp_q.pop_front();
            if (int'(e[47:16]) != cyc || {4'b0, rsp_valid[l]} !== e[15:8] || rsp_data[l] !== e[7:0]) begin
              errors++;
              $display("FAIL rsp lane%0d cyc%0d got valid=%b data=%h want cyc%0d valid=%b data=%h",
                       l, cyc, rsp_valid[l], rsp_data[l], e[47:16], e[11:8], e[7:0]);
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step_agents(input int raise_pct, input bit allow_drop, input bit ls_rand);
    @(negedge clk);
    for (int l = 0; l < L; l++) begin
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[l][i]) begin
          wait_rsp[l][i] = 1'b0;
          if (raise_pct > 0 && $urandom_range(0, 3) == 0) begin
            req_addr[l][i*AW +: AW] = AW'($urandom);
          end else begin
            req[l][i] = 1'b0;
          end
        end else if (gnt[l][i]) begin
          wait_rsp[l][i] = 1'b1;
          if (allow_drop && $urandom_range(0, 3) == 0) req[l][i] = 1'b0;
        end else if (!req[l][i] && !wait_rsp[l][i] && $urandom_range(0, 99) < raise_pct) begin
          req[l][i] = 1'b1;
          req_addr[l][i*AW +: AW] = AW'($urandom);
        end
      end
    end
    line_start = ls_rand && ($urandom_range(0, 15) == 0);
  endtask

  task automatic raise_all(input logic [N-1:0] mask);
    for (int l = 0; l < L; l++) begin
      req[l] = mask;
      for (int i = 0; i < N; i++) req_addr[l][i*AW +: AW] = AW'($urandom);
    end
  endtask

  task automatic check_zero(input string name);
    for (int l = 0; l < L; l++) begin
      checks++;
      if (gnt[l] !== '0 || rsp_valid[l] !== '0 || rsp_data[l] !== '0 || rom_addr[l] !== '0 ||
          rom_en[l] !== 1'b0 || busy[l] !== 1'b0) begin
        errors++;
        $display("FAIL %s lane%0d got gnt=%b rsp_valid=%b data=%h addr=%h en=%b busy=%b want all 0",
                 name, l, gnt[l], rsp_valid[l], rsp_data[l], rom_addr[l], rom_en[l], busy[l]);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b1;
    line_start = 1'b0;
    for (int l = 0; l < L; l++) begin
      req[l] = '0;
      req_addr[l] = '0;
      wait_rsp[l] = '0;
    end
    for (int k = 0; k < 16; k++) rom_mem[k] = DW'($urandom);
    rom_mem[5] = 8'hA5;
    repeat (2) @(negedge clk);
    check_zero("reset_values");
    reset = 1'b0;

    // Single request from renderer 0 at row 5.
    @(negedge clk);
    for (int l = 0; l < L; l++) begin
      req[l] = 4'b0001;
      req_addr[l][3:0] = 4'h5;
    end
    repeat (10) step_agents(0, 1'b0, 1'b0);

    // All four requesting, twice in a row.
    raise_all(4'b1111);
    repeat (30) step_agents(0, 1'b0, 1'b0);
    raise_all(4'b1111);
    repeat (30) step_agents(0, 1'b0, 1'b0);

    // Serve renderer 2, rewind with line_start, then everyone requests.
    raise_all(4'b0100);
    repeat (12) step_agents(0, 1'b0, 1'b0);
    @(negedge clk);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    raise_all(4'b1111);
    repeat (30) step_agents(0, 1'b0, 1'b0);

    // Randomised traffic with early drops and scanline rewinds.
    repeat (800) step_agents(25, 1'b1, 1'b1);
    repeat (40) step_agents(0, 1'b0, 1'b0);

    // Reset while the latency-2 instance sits in WAIT.
    raise_all(4'b1111);
    n = 0;
    while (fsm_state[1] != WAIT && n < 50) begin
      step_agents(0, 1'b0, 1'b0);
      n++;
    end
    checks++;
    if (fsm_state[1] != WAIT) begin
      errors++;
      $display("FAIL reach_wait got state=%0d want %0d", fsm_state[1], WAIT);
    end
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    for (int l = 0; l < L; l++) wait_rsp[l] = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) step_agents(0, 1'b0, 1'b0);

    for (int l = 0; l < L; l++) begin
      raise_all(4'b0000);
    end
    repeat (5) step_agents(0, 1'b0, 1'b0);
    checks++;
    if (lane_g[0].exp_gnt_q.size() != 0 || lane_g[0].exp_rsp_q.size() != 0) begin
      errors++;
      $display("FAIL drain lane0 got pending gnt=%0d rsp=%0d want 0 0",
               lane_g[0].exp_gnt_q.size(), lane_g[0].exp_rsp_q.size());
    end
    checks++;
    if (lane_g[1].exp_gnt_q.size() != 0 || lane_g[1].exp_rsp_q.size() != 0) begin
      errors++;
      $display("FAIL drain lane1 got pending gnt=%0d rsp=%0d want 0 0",
               lane_g[1].exp_gnt_q.size(), lane_g[1].exp_rsp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
